// File: rtl/coa_seq_mac_pkg.sv
// Shared types and configuration for the coa_seq_mac multiply-add unit.
// Define COA_RADIX4_EN to retire two multiplier bits per cycle instead of one.
package coa_seq_mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic COA_MODE_MAC = 1'b0;
  localparam logic COA_MODE_ACC = 1'b1;

`ifdef COA_RADIX4_EN
  localparam int unsigned RADIX_BITS = 2;
`else
  localparam int unsigned RADIX_BITS = 1;
`endif

  // Number of CALC iterations for an operand width; odd widths round up under radix-4.
  function automatic int unsigned coa_steps(input int unsigned w);
    return (w + RADIX_BITS - 1) / RADIX_BITS;
  endfunction

endpackage

// File: rtl/coa_seq_mac_if.sv
// Operand and result handshake bundle for coa_seq_mac.
interface coa_seq_mac_if #(
  parameter int unsigned W = 5
);
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [W-1:0]   C;
  logic           mode;
  logic           valid_in;
  logic           ready_in;
  logic [2*W-1:0] D;
  logic           ovf;
  logic           valid_out;
  logic           ready_out;

  modport master (
    output A, B, C, mode, valid_in, ready_out,
    input  ready_in, D, ovf, valid_out
  );

  modport slave (
    input  A, B, C, mode, valid_in, ready_out,
    output ready_in, D, ovf, valid_out
  );
endinterface

// File: rtl/coa_seq_mac_step.sv
// Single-iteration accumulate adder: one partial product into the accumulator.
module coa_seq_mac_step #(
  parameter int unsigned DW = 10
) (
  input  logic [DW-1:0] acc,
  input  logic [DW-1:0] pp,
  output logic [DW-1:0] sum_c,
  output logic          carry_c
);
  assign {carry_c, sum_c} = (DW+1)'(acc) + (DW+1)'(pp);
endmodule

// File: rtl/coa_seq_mac.sv
// Iterative shift-add multiply-add: D = A*B + C, or D = A*B + D_prev in accumulate mode.
// COA_RADIX4_EN selects the two-bits-per-cycle datapath; default is radix-2.
module coa_seq_mac
  import coa_seq_mac_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input logic         clk,
  input logic         rst,
  coa_seq_mac_if.slave bus
);
  localparam int unsigned DW    = 2 * W;
  localparam int unsigned STEPS = coa_steps(W);
  localparam int unsigned BW    = STEPS * RADIX_BITS;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_e        state, state_n;
  logic [DW-1:0] acc, acc_n;
  logic [DW-1:0] d_prev, d_prev_n;
  logic [DW-1:0] mult, mult_n;
  logic [BW-1:0] mplr, mplr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          ovf_q, ovf_n;
  logic          ready_q, valid_q;
  logic [DW-1:0] pp_c, sum_c;
  logic          carry_c;
`ifdef COA_RADIX4_EN
  logic [DW-1:0] mult3, mult3_n;
`endif

  // Partial product for the multiplier digit currently at the bottom of mplr.
  always_comb begin
    pp_c = '0;
`ifdef COA_RADIX4_EN
    case (mplr[1:0])
      2'd1:    pp_c = mult;
      2'd2:    pp_c = mult << 1;
      2'd3:    pp_c = mult3;
      default: pp_c = '0;
    endcase
`else
    if (mplr[0]) pp_c = mult;
`endif
  end

  coa_seq_mac_step #(.DW(DW)) u_step (
    .acc     (acc),
    .pp      (pp_c),
    .sum_c   (sum_c),
    .carry_c (carry_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_n  = state;
    acc_n    = acc;
    ovf_n    = ovf_q;
    d_prev_n = d_prev;
    mult_n   = mult;
    mplr_n   = mplr;
    cnt_n    = cnt;
`ifdef COA_RADIX4_EN
    mult3_n  = mult3;
`endif
    unique case (state)
      IDLE: begin
        if (bus.valid_in) begin
          state_n = CALC;
          acc_n   = (bus.mode == COA_MODE_ACC) ? d_prev : DW'(bus.C);
          ovf_n   = 1'b0;
          mult_n  = DW'(bus.A);
`ifdef COA_RADIX4_EN
          mult3_n = DW'(bus.A) + (DW'(bus.A) << 1);
`endif
          mplr_n  = BW'(bus.B);
          cnt_n   = CW'(STEPS - 1);
        end
      end
      CALC: begin
        acc_n  = sum_c;
        if (carry_c) ovf_n = 1'b1;
        mult_n = mult << RADIX_BITS;
`ifdef COA_RADIX4_EN
        mult3_n = mult3 << RADIX_BITS;
`endif
        mplr_n = mplr >> RADIX_BITS;
        cnt_n  = cnt - CW'(1);
        if (cnt == '0) state_n = DONE;
      end
      DONE: begin
        if (bus.ready_out) begin
          d_prev_n = acc;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      ovf_q   <= 1'b0;
      d_prev  <= '0;
      mult    <= '0;
      mplr    <= '0;
      cnt     <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
`ifdef COA_RADIX4_EN
      mult3   <= '0;
`endif
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      ovf_q   <= ovf_n;
      d_prev  <= d_prev_n;
      mult    <= mult_n;
      mplr    <= mplr_n;
      cnt     <= cnt_n;
      ready_q <= (state_n == IDLE);
      valid_q <= (state_n == DONE);
`ifdef COA_RADIX4_EN
      mult3   <= mult3_n;
`endif
    end
  end

  assign bus.ready_in  = ready_q;
  assign bus.valid_out = valid_q;
  assign bus.D         = acc;
  assign bus.ovf       = ovf_q;

endmodule
